// File: rtl/ul_rx_if.sv
// Uplink receive bus: serial line, envelope and frame config in; parallel frame and status out.
interface ul_rx_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 8,
  parameter int unsigned DIV_WIDTH  = 8
);
  localparam int unsigned WW = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned DW = $clog2(DATA_DEPTH) + 1;

  logic                                   ul_in;
  logic                                   ul_en;
  logic [DIV_WIDTH-1:0]                   clk_div;
  logic [WW-1:0]                          width;
  logic [DW-1:0]                          depth;
  logic                                   err_clear;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0]  par_out;
  logic                                   par_valid;
  logic                                   ul_done;
  logic                                   train_err;
  logic                                   frame_err;
  logic                                   busy;

  modport master (
    output ul_in, ul_en, clk_div, width, depth, err_clear,
    input  par_out, par_valid, ul_done, train_err, frame_err, busy
  );

  modport slave (
    input  ul_in, ul_en, clk_div, width, depth, err_clear,
    output par_out, par_valid, ul_done, train_err, frame_err, busy
  );
endinterface

// File: rtl/ul_rx_controller.sv
// Uplink receiver: checks the alternating training preamble, then deserializes a
// width x depth payload (row 0 first, MSB first) into a parallel buffer.
module ul_rx_controller #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DATA_DEPTH     = 8,
  parameter int unsigned PREAMBLE_COUNT = 8,
  parameter int unsigned DIV_WIDTH      = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  ul_rx_if.slave   bus
);
  localparam int unsigned WW = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned DW = $clog2(DATA_DEPTH) + 1;
  localparam int unsigned PW = $clog2(PREAMBLE_COUNT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_TRAINING, S_DESER, S_DRAIN} state_e;

  state_e                                 state_q;
  logic                                   en_q;
  logic [DIV_WIDTH-1:0]                   div_q;
  logic [DIV_WIDTH-1:0]                   phase_q;
  logic [WW-1:0]                          width_q;
  logic [WW-1:0]                          col_q;
  logic [DW-1:0]                          depth_q;
  logic [DW-1:0]                          row_q;
  logic [PW-1:0]                          idx_q;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0]  par_q;
  logic                                   valid_q;
  logic                                   done_q;
  logic                                   train_err_q;
  logic                                   frame_err_q;
  logic                                   busy_q;

  logic sample_c;
  logic wrap_c;
  logic last_c;
  logic pre_bit_c;

  assign sample_c  = (phase_q == (div_q >> 1));
  assign wrap_c    = (phase_q == div_q);
  assign last_c    = (row_q == depth_q) && (col_q == '0);
  assign pre_bit_c = ~idx_q[0];

  assign bus.par_out   = par_q;
  assign bus.par_valid = valid_q;
  assign bus.ul_done   = done_q;
  assign bus.train_err = train_err_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

  // en_q resets high so a line already enveloped at reset release is not a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      en_q        <= 1'b1;
      div_q       <= '0;
      phase_q     <= '0;
      width_q     <= '0;
      col_q       <= '0;
      depth_q     <= '0;
      row_q       <= '0;
      idx_q       <= '0;
      par_q       <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      train_err_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      en_q   <= bus.ul_en;
      done_q <= 1'b0;
      if (bus.err_clear) begin
        train_err_q <= 1'b0;
        frame_err_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.ul_en && !en_q) begin
            state_q <= S_TRAINING;
            busy_q  <= 1'b1;
            width_q <= bus.width;
            depth_q <= bus.depth;
            div_q   <= bus.clk_div;
            col_q   <= bus.width;
            row_q   <= '0;
            par_q   <= '0;
            valid_q <= 1'b0;
            phase_q <= '0;
            idx_q   <= '0;
          end
        end
        S_TRAINING: begin
          if (!bus.ul_en) begin
            frame_err_q <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
          end else begin
            phase_q <= wrap_c ? '0 : phase_q + DIV_WIDTH'(1);
            if (wrap_c) begin
              if (idx_q == PW'(PREAMBLE_COUNT - 1)) begin
                state_q <= S_DESER;
                idx_q   <= '0;
              end else begin
                idx_q <= idx_q + PW'(1);
              end
            end
            // A mismatch overrides the end-of-preamble move when both land on one cycle.
            if (sample_c && (bus.ul_in != pre_bit_c)) begin
              train_err_q <= 1'b1;
              state_q     <= S_DRAIN;
            end
          end
        end
        S_DESER: begin
          if (!bus.ul_en) begin
            frame_err_q <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
          end else begin
            phase_q <= wrap_c ? '0 : phase_q + DIV_WIDTH'(1);
            if (sample_c) begin
              for (int r = 0; r < int'(DATA_DEPTH); r++) begin
                for (int c = 0; c < int'(DATA_WIDTH); c++) begin
                  if ((row_q == DW'(r)) && (col_q == WW'(c))) par_q[r][c] <= bus.ul_in;
                end
              end
              if (last_c) begin
                done_q  <= 1'b1;
                valid_q <= 1'b1;
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else if (col_q == '0) begin
                col_q <= width_q;
                row_q <= row_q + DW'(1);
              end else begin
                col_q <= col_q - WW'(1);
              end
            end
          end
        end
        S_DRAIN: begin
          if (!bus.ul_en) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ul_rx_controller.sv
// Bench for ul_rx_controller: directed frame table plus random frames against a
// frame-level model (row-major MSB-first payload, masked to width/depth).
module tb_ul_rx_controller;
  localparam int unsigned DWID = 8;
  localparam int unsigned DDEP = 8;
  localparam int unsigned PC   = 8;
  localparam int unsigned DIVW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ul_rx_if #(.DATA_WIDTH(DWID), .DATA_DEPTH(DDEP), .DIV_WIDTH(DIVW)) bus ();

  ul_rx_controller #(
    .DATA_WIDTH(DWID), .DATA_DEPTH(DDEP), .PREAMBLE_COUNT(PC), .DIV_WIDTH(DIVW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled just after the edge so it never races the stimulus tasks.
  always @(posedge clk) begin
    #1;
    if (bus.ul_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  typedef struct {
    int          D;
    int          w;
    int          d;
    int          bad;
    int          trunc;
    int          clr;
    int          rst;
    int          gap;
    logic [63:0] want;
    bit          exp_tr;
    bit          exp_fr;
    bit          exp_val;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mask_of(input int w, input int d);
    logic [63:0] m = '0;
    for (int r = 0; r <= d; r++)
      for (int c = 0; c <= w; c++) m[r*8 + c] = 1'b1;
    return m;
  endfunction

  task automatic run_frame(input string tag, input vec_t v);
    bit          stream[$];
    int          n_tot, p0, drop_cyc, done0, exp_ndone;
    logic [63:0] st;
    for (int k = 0; k < int'(PC); k++) begin
      bit b = (k % 2 == 0);
      if (k == v.bad) b = ~b;
      stream.push_back(b);
    end
    for (int r = 0; r <= v.d; r++)
      for (int c = v.w; c >= 0; c--) stream.push_back(v.want[r*8 + c]);
    n_tot = stream.size();
    done0 = done_cnt;

    bus.clk_div = 8'(v.D);
    bus.width   = 4'(v.w);
    bus.depth   = 4'(v.d);
    bus.ul_in   = 1'b0;
    bus.ul_en   = 1'b1;
    @(negedge clk);
    p0 = cyc;
    chk({tag, "_start_valid"}, 64'(bus.par_valid), 64'd0);
    chk({tag, "_start_busy"}, 64'(bus.busy), 64'd1);

    for (int k = 0; k < n_tot; k++) begin
      if (k == v.trunc) break;
      bus.ul_in = stream[k];
      for (int p = 0; p <= v.D; p++) begin
        bus.err_clear = (k == v.clr) && (p == (v.D >> 1));
        if (k == v.rst && p == 0) begin
          rst_n = 1'b0;
          #1;
          chk({tag, "_rst_par"}, 64'(bus.par_out), 64'd0);
          st = 64'({bus.par_valid, bus.ul_done, bus.train_err, bus.frame_err, bus.busy});
          chk({tag, "_rst_status"}, st, 64'd0);
        end
        if (k == v.rst && p == 1) rst_n = 1'b1;
        @(negedge clk);
      end
    end
    bus.err_clear = 1'b0;
    drop_cyc  = cyc;
    bus.ul_en = 1'b0;
    bus.ul_in = 1'b0;
    repeat (v.gap) @(negedge clk);

    exp_ndone = (v.rst >= 0) ? 0 : 1;
    chk({tag, "_done_count"}, 64'(done_cnt - done0), 64'(exp_ndone));
    if (v.rst < 0) begin
      if (v.exp_val)
        chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(p0 + 1 + (n_tot - 1) * (v.D + 1) + (v.D >> 1)));
      else
        chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(drop_cyc + 1));
    end
    chk({tag, "_valid"}, 64'(bus.par_valid), 64'(v.exp_val));
    chk({tag, "_train_err"}, 64'(bus.train_err), 64'(v.exp_tr));
    chk({tag, "_frame_err"}, 64'(bus.frame_err), 64'(v.exp_fr));
    chk({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    if (v.exp_val) chk({tag, "_par_out"}, 64'(bus.par_out), v.want & mask_of(v.w, v.d));

    if (v.exp_tr || v.exp_fr) begin
      bus.err_clear = 1'b1;
      @(negedge clk);
      bus.err_clear = 1'b0;
      chk({tag, "_cleared"}, 64'({bus.train_err, bus.frame_err}), 64'd0);
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{D:3, w:7, d:6, bad:-1, trunc:-1, clr:-1, rst:-1, gap:3,
                want:64'hFF07060504030201, exp_tr:0, exp_fr:0, exp_val:1};
    vecs[1] = '{D:3, w:7, d:6, bad:3,  trunc:-1, clr:-1, rst:-1, gap:3,
                want:64'h0007060504030201, exp_tr:1, exp_fr:0, exp_val:0};
    vecs[2] = '{D:3, w:7, d:6, bad:-1, trunc:28, clr:-1, rst:-1, gap:3,
                want:64'h0007060504030201, exp_tr:0, exp_fr:1, exp_val:0};
    vecs[3] = '{D:0, w:3, d:1, bad:-1, trunc:-1, clr:-1, rst:-1, gap:1,
                want:64'h0000_0000_0000_0A05, exp_tr:0, exp_fr:0, exp_val:1};
    vecs[4] = '{D:0, w:3, d:1, bad:-1, trunc:-1, clr:-1, rst:-1, gap:3,
                want:64'hFFFF_FFFF_FFFF_F3F6, exp_tr:0, exp_fr:0, exp_val:1};
    vecs[5] = '{D:2, w:1, d:0, bad:3,  trunc:-1, clr:3,  rst:-1, gap:3,
                want:64'h0000_0000_0000_0002, exp_tr:1, exp_fr:0, exp_val:0};
    vecs[6] = '{D:3, w:7, d:3, bad:-1, trunc:-1, clr:-1, rst:12, gap:3,
                want:64'h0000_0000_A5C3_3C5A, exp_tr:0, exp_fr:0, exp_val:0};
    vecs[7] = '{D:1, w:4, d:5, bad:-1, trunc:-1, clr:-1, rst:-1, gap:2,
                want:64'h0000_1F0A_1513_0C11, exp_tr:0, exp_fr:0, exp_val:1};
    vecs[8] = '{D:1, w:2, d:2, bad:-1, trunc:5,  clr:-1, rst:-1, gap:2,
                want:64'h0000_0000_0005_0302, exp_tr:0, exp_fr:1, exp_val:0};
    vecs[9] = '{D:0, w:7, d:7, bad:0,  trunc:-1, clr:-1, rst:-1, gap:2,
                want:64'h0123_4567_89AB_CDEF, exp_tr:1, exp_fr:0, exp_val:0};

    bus.ul_in = 1'b0;
    bus.ul_en = 1'b0;
    bus.clk_div = '0;
    bus.width = '0;
    bus.depth = '0;
    bus.err_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_par", 64'(bus.par_out), 64'd0);
    chk("reset_status",
        64'({bus.par_valid, bus.ul_done, bus.train_err, bus.frame_err, bus.busy}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_frame($sformatf("v%0d", i), vecs[i]);

    // Random frames: good, bad preamble bit, or early envelope drop.
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int   kind, nb;
      v.D = int'($urandom_range(0, 3));
      v.w = int'($urandom_range(0, 7));
      v.d = int'($urandom_range(0, 7));
      v.want = {$urandom(), $urandom()};
      v.bad = -1; v.trunc = -1; v.clr = -1; v.rst = -1;
      v.gap = int'($urandom_range(1, 3));
      v.exp_tr = 0; v.exp_fr = 0; v.exp_val = 1;
      nb = int'(PC) + (v.w + 1) * (v.d + 1);
      kind = int'($urandom_range(0, 5));
      if (kind == 0) begin
        v.bad = int'($urandom_range(0, PC - 1));
        v.exp_tr = 1; v.exp_val = 0;
      end else if (kind == 1) begin
        v.trunc = int'($urandom_range(0, nb - 1));
        v.exp_fr = 1; v.exp_val = 0;
      end
      run_frame($sformatf("r%0d", i), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ul_rx_controller.md
# ul_rx_controller

Uplink receive controller: the receiving end of the downlink framing produced by the transmit-side controller. It watches the serial line and its enable, checks the alternating training preamble, then deserializes a `width × depth` payload into a parallel buffer for the descrambler/decoder. It reports completion or a framing/training error to the register block. Line, enable and `clk_div` share the `clk` domain with the transmitter; there is no clock recovery.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: maximum bits per row (columns).
- `DATA_DEPTH`, default 8: maximum rows.
- `PREAMBLE_COUNT`, default 8: number of training bits.
- `DIV_WIDTH`, default 8: width of `clk_div`.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `ul_in`, in, 1: serial line.
- `ul_en`, in, 1: frame envelope. High for preamble plus payload.
- `clk_div`, in, `DIV_WIDTH`: bit period is `clk_div+1` cycles.
- `width`, in, `$clog2(DATA_WIDTH)+1`: columns minus one. Sampled at frame start.
- `depth`, in, `$clog2(DATA_DEPTH)+1`: rows minus one. Sampled at frame start.
- `par_out`, out, `[DATA_DEPTH-1:0][DATA_WIDTH-1:0]`: received payload.
- `par_valid`, out, 1: `par_out` holds a complete good frame.
- `ul_done`, out, 1: one-cycle pulse at end of every frame, good or bad.
- `train_err`, out, 1: sticky preamble mismatch flag.
- `frame_err`, out, 1: sticky flag for an early `ul_en` drop.
- `err_clear`, in, 1: single-cycle clear of both sticky flags.
- `busy`, out, 1: state is not `S_IDLE`.

## Operation
- States are `S_IDLE`, `S_TRAINING`, `S_DESER`, `S_DRAIN`.
- **`S_IDLE`:**
  - A rising edge of `ul_en` (registered `ul_en` low, current `ul_en` high) moves to `S_TRAINING`.
  - On that edge: latch `width`, `depth` and `clk_div`; zero `par_out`; clear `par_valid`; zero the bit-phase counter and the bit index.
- **Bit timing:**
  - The phase counter runs 0..`clk_div_r`, then wraps.
  - `ul_in` is sampled when phase equals `clk_div_r>>1`.
  - The bit index advances when the phase wraps.
- **`S_TRAINING`:**
  - Expected preamble bit k is 1 for even k and 0 for odd k.
  - A mismatch sets `train_err` and moves to `S_DRAIN`.
  - After sample `PREAMBLE_COUNT-1` and its phase wrap, move to `S_DESER` with bit index reset.
- **`S_DESER`:**
  - Sampled bit n goes to row r = n/(`width_r`+1), column c = `width_r` − n%(`width_r`+1). Row 0 comes first, MSB first within a row.
  - Column and row counters replace division: c decrements and wraps to `width_r`, at which point r increments.
  - Bits outside the latched `width`/`depth` remain 0.
  - After the sample at r=`depth_r`, c=0, the next cycle pulses `ul_done`, sets `par_valid`, and moves to `S_IDLE`. The remaining half-bit and `ul_en` fall are ignored.
- **`ul_en` low before the last sample** (in `S_TRAINING` or `S_DESER`): set `frame_err`, pulse `ul_done`, go to `S_IDLE` the same cycle. `par_valid` stays 0.
- **`S_DRAIN`:** wait for `ul_en` low, then pulse `ul_done` and go to `S_IDLE`.
- **Sticky flags:**
  - `err_clear` clears `train_err` and `frame_err`.
  - If a set and `err_clear` coincide, the set wins.
- **Reset mid-frame:** the block returns to `S_IDLE`. The remainder of that frame is ignored because no new rising edge of `ul_en` is seen while `ul_en` stays high.

## Timing
- **Reset values:**
  - `par_out`=0, `par_valid`=0, `ul_done`=0, `train_err`=0, `frame_err`=0, `busy`=0.
  - Internal `ul_en` register = 1, which prevents a false edge when reset is released while `ul_en` is high.
- **Frame start:** `ul_en` high at edge t0 means the first bit's phase 0 is cycle t0+1. This matches a transmitter that asserts `dl_en` one cycle after its state changes.
- **Sample points:** bit k is sampled at cycle t0+1+k·(D+1)+(D>>1), where D=`clk_div`.
- **Total bits:** N = `PREAMBLE_COUNT` + (`width`+1)(`depth`+1).
- **Completion:** `ul_done` and `par_valid` rise one cycle after the last sample.
- **Minimum `clk_div`:** `clk_div`=0 (1 cycle/bit) is legal; the sample point is phase 0.
- **`par_out` stability:** stable from `par_valid` high until the next frame start.
- **Output registering:** all outputs are registered; no combinational path from `ul_in`.

## Test plan
- **Good frame:** `clk_div`=3, `width`=7, `depth`=6, preamble 10101010, payload rows 0x01..0x07 → `ul_done` pulse at t0+1+(8+56)·4−4+1+1, `par_out` rows 0..6 = 0x01..0x07, row 7 = 0, `par_valid`=1, no errors.
- **Bad preamble:** bit 3 inverted → `train_err`=1, `ul_done` one cycle after `ul_en` falls, `par_valid`=0. Then `err_clear` → `train_err`=0.
- **Truncated frame:** `ul_en` dropped after 20 payload bits → `frame_err`=1, `ul_done` the same cycle, `par_valid`=0.
- **Fast rate and back-to-back frames:** `clk_div`=0, `width`=3, `depth`=1, frames separated by 1 idle cycle → both frames captured correctly. The second frame's start clears `par_valid`, which returns high at the end of that frame.
- **Reset mid-payload:** with `ul_en` held high → all outputs 0, no `ul_done`. The next clean frame is received correctly.
- **Flag priority:** `err_clear` asserted in the same cycle as a mismatch sample → `train_err`=1.
